ifu_inst_buf: RTL and testbench

- Instruction buffer between the fetch unit and the decode stage.
- Accepts fetched instructions from the IFU over a valid/ready handshake and queues them in a small circular FIFO.
- Presents the head entry to the decoder, which feeds the ID/EX pipe register.
- Honours the control unit's stall and flush bus so that stalls and redirects never lose or duplicate instructions.

---
 rtl/ifu_inst_buf.sv | 158 +++++++++++++++
 tb/tb_ifu_inst_buf.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_buf.sv
// ifu_inst_buf: fetch-to-decode instruction FIFO honouring CU stall/flush.
// Optional macro IFU_IB_BYPASS_EN forwards pushes through an empty buffer.
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 2
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module ifu_inst_buf #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`CU_BUS_WIDTH-1:0]    stall_flag_i,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [`INST_ADDR_WIDTH-1:0] inst_addr_i,
  input  logic [`INST_DATA_WIDTH-1:0] inst_i,
  input  logic                        is_pred_branch_i,
  input  logic                        fetch_err_i,
  output logic                        inst_valid_o,
  output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic [`INST_DATA_WIDTH-1:0] inst_o,
  output logic                        is_pred_branch_o,
  output logic                        fetch_err_o,
  output logic [PTR_W:0]              count_o,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [`INST_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [`INST_DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]            pred_mem;
  logic [DEPTH-1:0]            err_mem;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic flush;
  logic stall;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  assign flush = stall_flag_i[`CU_FLUSH];
  assign stall = stall_flag_i[`CU_STALL];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign push_ready_o = ~full;
  assign count_o      = count;
  assign empty_o      = empty;
  assign full_o       = full;

  assign push = push_valid_i & push_ready_o & ~flush;
  assign pop  = inst_valid_o & ~stall & ~flush;

`ifdef IFU_IB_BYPASS_EN
  logic byp;
  assign byp   = empty & ~flush & push_valid_i;
  // a forwarded word consumed this cycle never touches storage
  assign wr_en = push & ~(byp & pop);
  assign rd_en = pop & ~byp;
`else
  assign wr_en = push;
  assign rd_en = pop;
`endif

  // head presentation; zeroed when nothing is valid
  always_comb begin
    inst_valid_o     = 1'b0;
    inst_addr_o      = '0;
    inst_o           = '0;
    is_pred_branch_o = 1'b0;
    fetch_err_o      = 1'b0;
    if (!empty) begin
      inst_valid_o     = 1'b1;
      inst_addr_o      = addr_mem[rd_ptr];
      inst_o           = inst_mem[rd_ptr];
      is_pred_branch_o = pred_mem[rd_ptr];
      fetch_err_o      = err_mem[rd_ptr];
    end
`ifdef IFU_IB_BYPASS_EN
    else if (byp) begin
      inst_valid_o     = 1'b1;
      inst_addr_o      = inst_addr_i;
      inst_o           = inst_i;
      is_pred_branch_o = is_pred_branch_i;
      fetch_err_o      = fetch_err_i;
    end
`endif
  end

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= inst_addr_i;
      inst_mem[wr_ptr] <= inst_i;
      pred_mem[wr_ptr] <= is_pred_branch_i;
      err_mem[wr_ptr]  <= fetch_err_i;
    end
  end

  // pointers and occupancy; flush empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full));
  a_cnt_max: assert property (
    @(posedge clk) disable iff (rst) count <= FULL_CNT);
`ifdef IFU_IB_BYPASS_EN
  a_valid_empty: assert property (
    @(posedge clk) disable iff (rst)
    inst_valid_o == (~empty_o | byp));
`else
  a_valid_empty: assert property (
    @(posedge clk) disable iff (rst)
    inst_valid_o == ~empty_o);
`endif
`endif

endmodule

// File: tb/tb_ifu_inst_buf.sv
// tb_ifu_inst_buf: directed bench with a queue model checked every cycle.
// Literal checks pin the model; bypass checks under IFU_IB_BYPASS_EN.
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 2
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module tb_ifu_inst_buf;
  localparam int DEPTH = 4;
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [`INST_ADDR_WIDTH-1:0] addr;
    logic [`INST_DATA_WIDTH-1:0] inst;
    logic                        pred;
    logic                        err;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [`CU_BUS_WIDTH-1:0] stall_flag_i;
  logic push_valid_i;
  logic push_ready_o;
  logic [`INST_ADDR_WIDTH-1:0] inst_addr_i;
  logic [`INST_DATA_WIDTH-1:0] inst_i;
  logic is_pred_branch_i;
  logic fetch_err_i;
  logic inst_valid_o;
  logic [`INST_ADDR_WIDTH-1:0] inst_addr_o;
  logic [`INST_DATA_WIDTH-1:0] inst_o;
  logic is_pred_branch_o;
  logic fetch_err_o;
  logic [PW:0] count_o;
  logic empty_o;
  logic full_o;

  ifu_inst_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .stall_flag_i(stall_flag_i),
    .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o),
    .inst_addr_i(inst_addr_i),
    .inst_i(inst_i),
    .is_pred_branch_i(is_pred_branch_i),
    .fetch_err_i(fetch_err_i),
    .inst_valid_o(inst_valid_o),
    .inst_addr_o(inst_addr_o),
    .inst_o(inst_o),
    .is_pred_branch_o(is_pred_branch_o),
    .fetch_err_o(fetch_err_o),
    .count_o(count_o),
    .empty_o(empty_o),
    .full_o(full_o)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] i,
                              input logic p, input logic e);
    ent_t r;
    r.addr = a;
    r.inst = i;
    r.pred = p;
    r.err  = e;
    return r;
  endfunction

  task automatic drive(input logic pv, input ent_t e,
                       input logic st, input logic fl);
    push_valid_i     = pv;
    inst_addr_i      = e.addr;
    inst_i           = e.inst;
    is_pred_branch_i = e.pred;
    fetch_err_i      = e.err;
    stall_flag_i     = '0;
    stall_flag_i[`CU_STALL] = st;
    stall_flag_i[`CU_FLUSH] = fl;
  endtask

  // compare DUT to model at negedge, then advance model over posedge
  task automatic tick(output logic acc);
    logic st, fl, full_e, valid_e, pop_e, byp_e;
    ent_t head, cur;
    @(negedge clk);
    st  = stall_flag_i[`CU_STALL];
    fl  = stall_flag_i[`CU_FLUSH];
    cur = mk(inst_addr_i, inst_i, is_pred_branch_i, fetch_err_i);
    full_e  = (q.size() == DEPTH);
    byp_e   = 1'b0;
    head    = '0;
    valid_e = (q.size() != 0);
    if (valid_e) head = q[0];
`ifdef IFU_IB_BYPASS_EN
    else if (push_valid_i && !fl) begin
      byp_e   = 1'b1;
      valid_e = 1'b1;
      head    = cur;
    end
`endif
    chk("inst_valid", inst_valid_o, valid_e);
    chk("push_ready", push_ready_o, !full_e);
    chk("count", count_o, q.size());
    chk("empty", empty_o, q.size() == 0);
    chk("full", full_o, full_e);
    chk("head_addr", inst_addr_o, head.addr);
    chk("head_inst", inst_o, head.inst);
    chk("head_pred", is_pred_branch_o, head.pred);
    chk("head_err", fetch_err_o, head.err);
    acc   = push_valid_i && !full_e && !fl;
    pop_e = valid_e && !st && !fl;
    if (fl) q.delete();
    else begin
      if (pop_e && !byp_e) void'(q.pop_front());
      if (acc && !(pop_e && byp_e)) q.push_back(cur);
    end
    @(posedge clk);
    #1;
    push_valid_i = 1'b0;
    stall_flag_i = '0;
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      tick(a);
    end
  endtask

  task automatic push_word(input ent_t e, input logic st);
    logic a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      drive(1'b1, e, st, 1'b0);
      tick(a);
      tries++;
    end
    if (!a) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    ent_t w[5];
    int idx;
    int cyc;

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_ready", push_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_addr", inst_addr_o, 0);
    chk("rst_inst", inst_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    idle(2);

    // three PCs back to back, no stall
    push_word(mk(32'h80000000, 32'h00100093, 1'b0, 1'b0), 1'b0);
`ifndef IFU_IB_BYPASS_EN
    chk("seq0_addr", inst_addr_o, 32'h80000000);
    chk("seq0_cnt", count_o, 1);
`endif
    push_word(mk(32'h80000004, 32'h00200113, 1'b1, 1'b0), 1'b0);
`ifndef IFU_IB_BYPASS_EN
    chk("seq1_addr", inst_addr_o, 32'h80000004);
    chk("seq1_pred", is_pred_branch_o, 1);
    chk("seq1_cnt", count_o, 1);
`endif
    push_word(mk(32'h80000008, 32'h00300193, 1'b0, 1'b1), 1'b0);
`ifndef IFU_IB_BYPASS_EN
    chk("seq2_addr", inst_addr_o, 32'h80000008);
    chk("seq2_err", fetch_err_o, 1);
    chk("seq2_cnt", count_o, 1);
`endif
    idle(2);
    chk("seq_drained", inst_valid_o, 0);

    // stalled fill to full, fifth word waits for a pop
    for (int i = 0; i < 5; i++)
      w[i] = mk(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), i[0], 1'b0);
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b1);
    chk("fill_cnt", count_o, 4);
    chk("fill_full", full_o, 1);
    chk("fill_ready", push_ready_o, 0);
    drive(1'b1, w[4], 1'b1, 1'b0);
    tick(a);
    chk("w4_held", count_o, 4);
    drive(1'b1, w[4], 1'b0, 1'b0);
    tick(a);
    chk("w4_no_adm", count_o, 3);
    chk("w4_head", inst_addr_o, 32'h204);
    push_word(w[4], 1'b0);
    idle(6);
    chk("fill_drained", count_o, 0);

    // flush at 3 entries with a push in the same cycle
    for (int i = 0; i < 3; i++) push_word(w[i], 1'b1);
    chk("pre_flush_cnt", count_o, 3);
    drive(1'b1, mk(32'hDEAD0000, 32'hDEADBEEF, 1'b0, 1'b0), 1'b0, 1'b1);
    tick(a);
    chk("flush_cnt", count_o, 0);
    chk("flush_valid", inst_valid_o, 0);
    idle(2);
    chk("flush_nodrop", inst_valid_o, 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) push_word(w[i], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", count_o, 0);
    chk("arst_valid", inst_valid_o, 0);
    chk("arst_empty", empty_o, 1);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    idle(1);

    // 3*DEPTH words with random stalls and gaps
    idx = 0;
    cyc = 0;
    while (idx < 3 * DEPTH && cyc < 400) begin
      drive($urandom_range(0, 3) != 0,
            mk(32'h1000 + 32'(idx * 4), 32'h5000 + 32'(idx),
               idx[1], idx[2]),
            $urandom_range(0, 2) == 0, 1'b0);
      tick(a);
      if (a) idx++;
      cyc++;
    end
    if (idx != 3 * DEPTH) chk("rand_timeout", 64'(idx), 64'(3 * DEPTH));
    idle(DEPTH + 2);
    chk("rand_drained", count_o, 0);

`ifdef IFU_IB_BYPASS_EN
    drive(1'b1, mk(32'h100, 32'h00000013, 1'b0, 1'b0), 1'b0, 1'b0);
    #1;
    chk("byp_valid", inst_valid_o, 1);
    chk("byp_inst", inst_o, 32'h00000013);
    chk("byp_addr", inst_addr_o, 32'h100);
    chk("byp_cnt", count_o, 0);
    tick(a);
    chk("byp_after_cnt", count_o, 0);
    chk("byp_after_valid", inst_valid_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
